// File: rtl/regfile_pkg.sv
// Shared definitions for the multiport register file: default geometry,
// address/data typedefs and the hard-wired zero register index.
package regfile_pkg;

  localparam int unsigned DEF_DW = 16;
  localparam int unsigned DEF_AW = 5;
  localparam int unsigned DEF_NR = 2;
  localparam int unsigned DEF_NW = 2;

  // Register index that always reads zero and ignores writes/claims.
  localparam int unsigned ZERO_REG = 0;

  typedef logic [DEF_AW-1:0] reg_addr_t;
  typedef logic [DEF_DW-1:0] reg_data_t;

endpackage

// File: rtl/regfile_read_port.sv
// One read port of the register file: address decode, optional
// write-to-read bypass (REGFILE_BYPASS_EN) and busy-bit lookup.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int unsigned DW = DEF_DW,
  parameter int unsigned AW = DEF_AW,
  parameter int unsigned NW = DEF_NW
) (
  input  logic [AW-1:0]                  rs_add_i,
  input  logic [(2**AW)-1:0][DW-1:0]     mem_i,
  input  logic [(2**AW)-1:0]             busy_i,
  input  logic [NW*AW-1:0]               rd_add_i,
  input  logic [NW-1:0]                  enw_i,
  input  logic [NW*DW-1:0]               write_data_i,
  output logic [DW-1:0]                  read_o,
  output logic                           rs_busy_o
);

`ifdef REGFILE_BYPASS_EN
  localparam bit BypassOn = 1'b1;
`else
  localparam bit BypassOn = 1'b0;
`endif

  logic          hit;
  logic [DW-1:0] hit_data;

  // Find the highest-index enabled write port targeting this read address.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    for (int unsigned w = 0; w < NW; w++) begin
      if (enw_i[w] && (rd_add_i[w*AW +: AW] == rs_add_i)) begin
        hit      = 1'b1;
        hit_data = write_data_i[w*DW +: DW];
      end
    end
  end

  // Select read data and busy flag; register 0 is constant zero and never busy.
  always_comb begin
    if (rs_add_i == AW'(ZERO_REG)) begin
      read_o    = '0;
      rs_busy_o = 1'b0;
    end else if (BypassOn && hit) begin
      read_o    = hit_data;
      rs_busy_o = 1'b0;
    end else begin
      read_o    = mem_i[rs_add_i];
      rs_busy_o = busy_i[rs_add_i];
    end
  end

endmodule

// File: rtl/multiport_register_file.sv
// Multiport register file with zero register, write-port priority (higher
// index wins), per-register busy scoreboard and optional write-to-read bypass
// enabled by the REGFILE_BYPASS_EN macro.
module multiport_register_file
  import regfile_pkg::*;
#(
  parameter int unsigned DW = DEF_DW,
  parameter int unsigned AW = DEF_AW,
  parameter int unsigned NR = DEF_NR,
  parameter int unsigned NW = DEF_NW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NR*AW-1:0]  rs_add,
  output logic [NR*DW-1:0]  read,
  output logic [NR-1:0]     rs_busy,
  input  logic [NW*AW-1:0]  rd_add,
  input  logic [NW-1:0]     enw,
  input  logic [NW*DW-1:0]  write_data,
  input  logic              sb_set,
  input  logic [AW-1:0]     sb_add
);

  logic [(2**AW)-1:0][DW-1:0] mem_q, mem_d;
  logic [(2**AW)-1:0]         busy_q, busy_d;

  // Next-state storage and scoreboard; later ports overwrite earlier ones,
  // and an issue claim is applied after retiring writes so set beats clear.
  always_comb begin
    mem_d  = mem_q;
    busy_d = busy_q;
    for (int unsigned w = 0; w < NW; w++) begin
      if (enw[w] && (rd_add[w*AW +: AW] != AW'(ZERO_REG))) begin
        mem_d[rd_add[w*AW +: AW]]  = write_data[w*DW +: DW];
        busy_d[rd_add[w*AW +: AW]] = 1'b0;
      end
    end
    if (sb_set && (sb_add != AW'(ZERO_REG))) begin
      busy_d[sb_add] = 1'b1;
    end
  end

  // State update with synchronous reset overriding writes and claims.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q  <= '0;
      busy_q <= '0;
    end else begin
      mem_q  <= mem_d;
      busy_q <= busy_d;
    end
  end

  for (genvar r = 0; r < NR; r++) begin : g_rd
    regfile_read_port #(
      .DW(DW),
      .AW(AW),
      .NW(NW)
    ) u_read_port (
      .rs_add_i     (rs_add[r*AW +: AW]),
      .mem_i        (mem_q),
      .busy_i       (busy_q),
      .rd_add_i     (rd_add),
      .enw_i        (enw),
      .write_data_i (write_data),
      .read_o       (read[r*DW +: DW]),
      .rs_busy_o    (rs_busy[r])
    );
  end

endmodule

// File: tb/tb_multiport_register_file.sv
// Self-checking bench for multiport_register_file: directed scenarios with
// literal expectations plus randomized traffic against a behavioural model.
module tb_multiport_register_file;
  import regfile_pkg::*;

  localparam int DW = 16;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int NW = 2;
  localparam int DEPTH = 32;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NR*AW-1:0]  rs_add = '0;
  logic [NR*DW-1:0]  read;
  logic [NR-1:0]     rs_busy;
  logic [NW*AW-1:0]  rd_add = '0;
  logic [NW-1:0]     enw = '0;
  logic [NW*DW-1:0]  write_data = '0;
  logic              sb_set = 1'b0;
  logic [AW-1:0]     sb_add = '0;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  reg_data_t m_mem [DEPTH];
  bit        m_busy [DEPTH];

  multiport_register_file #(
    .DW(DW),
    .AW(AW),
    .NR(NR),
    .NW(NW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rs_add     (rs_add),
    .read       (read),
    .rs_busy    (rs_busy),
    .rd_add     (rd_add),
    .enw        (enw),
    .write_data (write_data),
    .sb_set     (sb_set),
    .sb_add     (sb_add)
  );

  always #5 clk = ~clk;

  // Reference model: architectural register contents and busy set.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_mem[i]  <= '0;
        m_busy[i] <= 1'b0;
      end
    end else begin
      for (int w = 0; w < NW; w++) begin
        int a;
        a = int'(rd_add[w*AW +: AW]);
        if (enw[w] && a != 0) begin
          m_mem[a]  <= write_data[w*DW +: DW];
          m_busy[a] <= 1'b0;
        end
      end
      if (sb_set && sb_add != 0) m_busy[int'(sb_add)] <= 1'b1;
    end
  end

  function automatic void model_port(input int r, output reg_data_t d, output bit b);
    int a;
    a = int'(rs_add[r*AW +: AW]);
    d = m_mem[a];
    b = m_busy[a];
    if (BYP) begin
      for (int w = 0; w < NW; w++) begin
        if (enw[w] && int'(rd_add[w*AW +: AW]) == a) begin
          d = write_data[w*DW +: DW];
          b = 1'b0;
        end
      end
    end
    if (a == 0) begin
      d = '0;
      b = 1'b0;
    end
  endfunction

  // Every-cycle comparison against the model, mid-cycle.
  always @(negedge clk) begin
    if (check_en) begin
      for (int r = 0; r < NR; r++) begin
        reg_data_t ed;
        bit        eb;
        model_port(r, ed, eb);
        checks++;
        if (read[r*DW +: DW] !== ed || rs_busy[r] !== eb) begin
          errors++;
          $display("FAIL model port%0d t=%0t read=%h busy=%b required read=%h busy=%b",
                   r, $time, read[r*DW +: DW], rs_busy[r], ed, eb);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    enw    = '0;
    sb_set = 1'b0;
    rst    = 1'b0;
  endtask

  task automatic set_rs(input int r, input int a);
    rs_add[r*AW +: AW] = AW'(a);
  endtask

  task automatic wr(input int w, input int a, input int d);
    enw[w]                 = 1'b1;
    rd_add[w*AW +: AW]     = AW'(a);
    write_data[w*DW +: DW] = DW'(d);
  endtask

  // Literal check of one read port, sampled at the falling edge.
  task automatic chk(input string name, input int r, input int ed, input bit eb);
    @(negedge clk);
    #0;
    checks++;
    if (read[r*DW +: DW] !== DW'(ed) || rs_busy[r] !== eb) begin
      errors++;
      $display("FAIL %s port%0d read=%h busy=%b required read=%h busy=%b",
               name, r, read[r*DW +: DW], rs_busy[r], DW'(ed), eb);
    end
  endtask

  initial begin
    // Reset
    rst = 1'b1;
    tick();
    idle();
    check_en = 1'b1;
    set_rs(0, 1); set_rs(1, 20);
    chk("reset_r1", 0, 0, 0);
    chk("reset_r20", 1, 0, 0);
    tick();

    // Dual write to distinct registers
    wr(0, 1, 16'hAAAA); wr(1, 5, 16'hBBBB);
    set_rs(0, 1); set_rs(1, 5);
    tick();
    idle();
    chk("dual_r1", 0, 16'hAAAA, 0);
    chk("dual_r5", 1, 16'hBBBB, 0);
    set_rs(1, 20);
    chk("untouched_r20", 1, 0, 0);
    tick();

    // Zero register ignores writes and claims
    wr(0, 0, 16'h1234); sb_set = 1'b1; sb_add = '0;
    set_rs(0, 0);
    tick();
    idle();
    chk("r0_write", 0, 0, 0);
    tick();

    // Collision: higher port wins
    wr(0, 10, 16'h1111); wr(1, 10, 16'h2222);
    tick();
    idle();
    set_rs(0, 10);
    chk("collision_r10", 0, 16'h2222, 0);
    tick();

    // Write/read same cycle
    wr(0, 7, 16'hCCCC);
    set_rs(0, 7);
    chk("r7_same_cycle", 0, BYP ? 16'hCCCC : 16'h0000, 0);
    tick();
    idle();
    chk("r7_next_cycle", 0, 16'hCCCC, 0);
    tick();

    // Scoreboard set, set-beats-clear, clear
    sb_set = 1'b1; sb_add = 5'd3;
    set_rs(0, 3);
    tick();
    idle();
    chk("busy_r3_set", 0, 0, 1);
    tick();
    wr(0, 3, 16'h0033); sb_set = 1'b1; sb_add = 5'd3;
    tick();
    idle();
    chk("busy_r3_set_wins", 0, 16'h0033, 1);
    tick();
    wr(1, 3, 16'h0044);
    chk("busy_r3_clear_same", 0, BYP ? 16'h0044 : 16'h0033, BYP ? 1'b0 : 1'b1);
    tick();
    idle();
    chk("busy_r3_cleared", 0, 16'h0044, 0);
    tick();

    // Reset mid-sequence discards the concurrent write and claim
    wr(0, 9, 16'hDEAD);
    tick();
    idle();
    set_rs(0, 9); set_rs(1, 2);
    chk("r9_written", 0, 16'hDEAD, 0);
    rst = 1'b1; wr(1, 2, 16'h5555); sb_set = 1'b1; sb_add = 5'd2;
    tick();
    idle();
    chk("rst_r9", 0, 0, 0);
    chk("rst_r2", 1, 0, 0);
    tick();

    // Randomized traffic over a narrow address window to force collisions
    for (int i = 0; i < 3000; i++) begin
      rst    = ($urandom_range(0, 63) == 0);
      enw    = NW'($urandom);
      sb_set = ($urandom_range(0, 3) == 0);
      sb_add = AW'($urandom_range(0, 7));
      for (int w = 0; w < NW; w++) begin
        rd_add[w*AW +: AW]     = AW'($urandom_range(0, 7));
        write_data[w*DW +: DW] = DW'($urandom);
      end
      for (int r = 0; r < NR; r++) set_rs(r, $urandom_range(0, 7));
      tick();
    end
    idle();
    @(negedge clk);
    #1;
    check_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multiport_register_file.md
# multiport_register_file

Parametrised general-purpose register file for the pipelined datapath. It generalises the 32 x 16-bit two-read/one-write file to configurable width, depth and read/write port count. It adds a hard-wired zero register, deterministic write-port priority, optional write-to-read bypass, and a per-register busy scoreboard that the decode stage uses for hazard detection. It sits between decode (read and issue side) and writeback (write side).

## Interface
- DW, 16, data width in bits
- AW, 5, address width; depth = 2**AW registers
- NR, 2, number of read ports (1..4)
- NW, 2, number of write ports (1..2)
- clk  input  1  single clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- rs_add  input  NR*AW  read addresses; port r occupies bits [r*AW +: AW]
- read  output  NR*DW  read data, combinational from rs_add
- rs_busy  output  NR  per-read-port flag: the addressed register has a pending producer
- rd_add  input  NW*AW  write addresses
- enw  input  NW  write enables
- write_data  input  NW*DW  write data
- sb_set  input  1  issue strobe: mark register sb_add busy
- sb_add  input  AW  register being claimed by the issuing instruction

## Operation
- Storage: 2**AW x DW. Register 0 always reads 0. Writes to register 0 are discarded, and sb_set on register 0 is ignored.
- Read: asynchronous. `read[r] = mem[rs_add[r]]`, or the bypass value if enabled (see Configuration).
- Write: on a clock edge with `enw[w]=1` and `rd_add[w]!=0`, `mem[rd_add[w]] <= write_data[w]`.
- Write collision (both ports, same address): the higher-index port wins. The lower port's data is dropped.
- Scoreboard: one busy bit per register.
  - Set: `sb_set=1` sets `busy[sb_add]` at the edge.
  - Clear: any enabled write clears `busy[rd_add[w]]` at the edge.
  - Set and clear on the same register in the same cycle: set wins, because the new producer supersedes the retiring one.
- `rs_busy[r] = busy[rs_add[r]]`, adjusted by bypass. `rs_busy` is always 0 for address 0.
- Reset: all registers and busy bits go to 0 at the first edge with rst=1. After reset, every `read` is 0 and every `rs_busy` is 0. Reset overrides any concurrent write or sb_set. A reset in the middle of a burst discards that cycle's writes.

## Timing
- Read latency: 0 cycles (combinational).
- Write visibility without bypass: the data is visible on `read` starting the cycle after the write edge.
- Scoreboard latency:
  - `rs_busy` rises the cycle after sb_set.
  - `rs_busy` falls the cycle after the clearing write, or in the same cycle when bypass is enabled.
- No handshake. The caller holds sb_set for exactly one cycle per issue. Repeated sets on a busy register are idempotent.
- Out-of-range parameters (NR>4, NW>2) are not supported and are not checked in RTL.

## Configuration
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - If any enabled write port targets `rs_add[r]` (non-zero) this cycle, `read[r]` returns that port's `write_data`. The higher-index port wins if both ports match.
  - `rs_busy[r]` is forced to 0 in the same case.
  - Effective write-to-read latency is 0 cycles.
- Undefined: reads return the stored value only. Decode must stall one extra cycle after writeback.

## Structure
- Shared package `regfile_pkg`:
  - constants for default DW/AW/NR/NW
  - `reg_addr_t` (AW bits) and `reg_data_t` (DW bits) typedefs
  - the constant `ZERO_REG = 0`
- One sub-module, `regfile_read_port`, instantiated NR times. It performs one address decode, the bypass match/priority mux and the busy lookup.
- Storage array, write logic and scoreboard stay in the top module.

## Test plan
- Reset, then write 0xAAAA to R1 (port0) and 0xBBBB to R5 (port1) in the same cycle; read R1/R5 next cycle -> 0xAAAA/0xBBBB. Read R20 -> 0x0000.
- Write 0x1234 to R0 -> R0 reads 0x0000. sb_set on R0 -> rs_busy stays 0.
- Both ports write R10 with 0x1111 (port0) and 0x2222 (port1) -> R10 reads 0x2222 after the edge.
- Write 0xCCCC to R7 while reading R7:
  - with REGFILE_BYPASS_EN -> read=0xCCCC in the same cycle
  - without it -> old value this cycle, 0xCCCC next cycle
- sb_set R3 -> rs_busy=1 next cycle. Write R3 while sb_set R3 in the same cycle -> busy stays 1. A later write to R3 alone -> busy 0 after the edge (same cycle with bypass).
- Write R9=0xDEAD, assert rst mid-sequence together with a write of R2=0x5555 -> after the edge all reads are 0x0000 and all rs_busy are 0.
